// File: rtl/ctr_keystream_xor.sv
// Purpose: XOR a streamed word flow with 128-bit AES-CTR keystream blocks, fetching a new block per 128 bits.
// Latency: start->ks_next 1 cycle; input transfer->out_valid 1 cycle; single-buffer bubble >= core latency + 3 between blocks.
// Backpressure: in_ready = XOR state && output register free or draining; out_data holds while out_valid && !out_ready.
// Optional: define CTR_KS_PREFETCH_EN to add a second keystream buffer filled concurrently with streaming.
module ctr_keystream_xor #(
  parameter int DATA_W = 32   // must divide 128: 8, 16, 32, 64 or 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ks_next,
  input  logic              ks_ready,
  input  logic [127:0]      ks_block,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [31:0]       blk_count
);

  localparam int WORDS = 128 / DATA_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int NSEL  = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DROP,
    S_WAIT,
    S_XOR
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [127:0]        ks_reg_q, ks_reg_d;
  logic [31:0]         blk_count_q, blk_count_d;
  logic                busy_q, busy_d;
  logic                ks_next_q, ks_next_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  logic                in_xfer;
  logic                start_ok;
  logic [DATA_W-1:0]   ks_word;
  logic [DATA_W-1:0]   ks_words [NSEL];

`ifdef CTR_KS_PREFETCH_EN
  // Prefetch engine: runs one core request/response cycle alongside streaming.
  typedef enum logic [1:0] {
    PF_IDLE,
    PF_REQ,
    PF_DROP,
    PF_WAIT
  } pf_t;

  pf_t                 pf_q, pf_d;
  logic [127:0]        ks_nxt_q, ks_nxt_d;
  logic                nxt_vld_q, nxt_vld_d;
  logic                pf_start;
`endif

  // Split the current block into words, MSB word first; unused slots pad to zero.
  for (genvar w = 0; w < NSEL; w++) begin : g_word
    if (w < WORDS) begin : g_used
      assign ks_words[w] = ks_reg_q[127 - w*DATA_W -: DATA_W];
    end else begin : g_pad
      assign ks_words[w] = '0;
    end
  end

  assign ks_word  = ks_words[idx_q];
  assign in_ready = (state_q == S_XOR) && (!out_valid_q || out_ready);
  assign in_xfer  = in_valid && in_ready;

  // A new message may only begin once the previous one has fully drained
  // (and, with prefetch, once any in-flight core run has completed).
`ifdef CTR_KS_PREFETCH_EN
  assign start_ok = !busy_q && (pf_q == PF_IDLE);
`else
  assign start_ok = !busy_q;
`endif

  // Next-state logic for the message FSM, output register and prefetch engine.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ks_reg_d    = ks_reg_q;
    blk_count_d = blk_count_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifdef CTR_KS_PREFETCH_EN
    pf_d        = pf_q;
    ks_nxt_d    = ks_nxt_q;
    nxt_vld_d   = nxt_vld_q;
    pf_start    = 1'b0;
`endif

    // Output register drains on acceptance; a same-cycle transfer below re-fills it.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      if (out_last_q) begin
        busy_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && start_ok) begin
          state_d     = S_REQ;
          blk_count_d = '0;
          idx_d       = '0;
          busy_d      = 1'b1;
`ifdef CTR_KS_PREFETCH_EN
          nxt_vld_d   = 1'b0;
`endif
        end
      end

      S_REQ: begin
        state_d = S_DROP;
      end

      // The core lowers ks_ready once it has taken the request.
      S_DROP: begin
        if (!ks_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
`ifdef CTR_KS_PREFETCH_EN
        if (nxt_vld_q) begin
          ks_reg_d    = ks_nxt_q;
          nxt_vld_d   = 1'b0;
          blk_count_d = blk_count_q + 32'd1;
          pf_start    = 1'b1;
          state_d     = S_XOR;
        end else if ((pf_q == PF_IDLE) && ks_ready) begin
          ks_reg_d    = ks_block;
          blk_count_d = blk_count_q + 32'd1;
          pf_start    = 1'b1;
          state_d     = S_XOR;
        end
`else
        if (ks_ready) begin
          ks_reg_d    = ks_block;
          blk_count_d = blk_count_q + 32'd1;
          state_d     = S_XOR;
        end
`endif
      end

      S_XOR: begin
        if (in_xfer) begin
          out_data_d  = in_data ^ ks_word;
          out_last_d  = in_last;
          out_valid_d = 1'b1;
          if (in_last) begin
            // Remainder of the current block is discarded.
            state_d = S_IDLE;
            idx_d   = '0;
`ifdef CTR_KS_PREFETCH_EN
            nxt_vld_d = 1'b0;
`endif
          end else if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef CTR_KS_PREFETCH_EN
            if (nxt_vld_q) begin
              // Buffered block takes over with no bubble.
              ks_reg_d    = ks_nxt_q;
              nxt_vld_d   = 1'b0;
              blk_count_d = blk_count_q + 32'd1;
              pf_start    = 1'b1;
            end else begin
              state_d = S_WAIT;
            end
`else
            state_d = S_REQ;
`endif
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef CTR_KS_PREFETCH_EN
    // Prefetch engine: a block arriving after the message ended is dropped.
    case (pf_q)
      PF_IDLE: begin
        if (pf_start) begin
          pf_d = PF_REQ;
        end
      end
      PF_REQ: begin
        pf_d = PF_DROP;
      end
      PF_DROP: begin
        if (!ks_ready) begin
          pf_d = PF_WAIT;
        end
      end
      PF_WAIT: begin
        if (ks_ready) begin
          pf_d = PF_IDLE;
          if (state_d != S_IDLE) begin
            ks_nxt_d  = ks_block;
            nxt_vld_d = 1'b1;
          end
        end
      end
      default: begin
        pf_d = PF_IDLE;
      end
    endcase

    ks_next_d = (state_d == S_REQ) || (pf_d == PF_REQ);
`else
    ks_next_d = (state_d == S_REQ);
`endif
  end

  // State and registered outputs; reset abandons any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ks_reg_q    <= '0;
      blk_count_q <= '0;
      busy_q      <= 1'b0;
      ks_next_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef CTR_KS_PREFETCH_EN
      pf_q        <= PF_IDLE;
      ks_nxt_q    <= '0;
      nxt_vld_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ks_reg_q    <= ks_reg_d;
      blk_count_q <= blk_count_d;
      busy_q      <= busy_d;
      ks_next_q   <= ks_next_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifdef CTR_KS_PREFETCH_EN
      pf_q        <= pf_d;
      ks_nxt_q    <= ks_nxt_d;
      nxt_vld_q   <= nxt_vld_d;
`endif
    end
  end

  assign ks_next   = ks_next_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign blk_count = blk_count_q;

endmodule

// File: tb/tb_ctr_keystream_xor.sv
`timescale 1ns/1ps
module tb_ctr_keystream_xor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         ks_next;
  logic         ks_ready;
  logic [127:0] ks_block;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic [31:0]  blk_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ctr_keystream_xor #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (rst),
    .start     (start),
    .ks_next   (ks_next),
    .ks_ready  (ks_ready),
    .ks_block  (ks_block),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .blk_count (blk_count)
  );

  // Core stub: drops ready after a ks_next pulse, returns the next table block after stub_lat cycles.
  logic [127:0] blk_tab [4];
  logic [1:0]   tab_idx;
  int           stub_lat = 3;
  int           stub_cnt;
  int           ks_pulses;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_ready  <= 1'b1;
      ks_block  <= '0;
      tab_idx   <= 2'd0;
      stub_cnt  <= 0;
      ks_pulses <= 0;
    end else if (ks_next) begin
      ks_ready  <= 1'b0;
      stub_cnt  <= stub_lat;
      ks_pulses <= ks_pulses + 1;
    end else if (!ks_ready) begin
      if (stub_cnt <= 1) begin
        ks_ready <= 1'b1;
        ks_block <= blk_tab[tab_idx];
        tab_idx  <= tab_idx + 2'd1;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  logic [31:0] tx_dat [$];
  logic [31:0] rx_dat [$];
  logic        rx_last [$];
  int          rx_cyc [$];
  logic [31:0] exp_dat [$];

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive tx_dat[0..n-1]; each word is held until a posedge with in_ready high takes it.
  task automatic send_words(input int n, input bit last_end);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      in_valid = 1'b1;
      in_data  = tx_dat[i];
      in_last  = last_end && (i == n - 1);
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        check_eq("in_ready_timeout", 128'(in_ready), 128'd1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv_words(input int n);
    int guard;
    guard = 0;
    rx_dat.delete(); rx_last.delete(); rx_cyc.delete();
    while (rx_dat.size() < n && guard < 400) begin
      @(negedge clk);
      guard++;
      if (out_valid && out_ready) begin
        rx_dat.push_back(out_data);
        rx_last.push_back(out_last);
        rx_cyc.push_back(cyc);
      end
    end
    check_eq("rx_count", 128'(rx_dat.size()), 128'(n));
  endtask

  task automatic check_rx(input string tname);
    for (int i = 0; i < rx_dat.size(); i++) begin
      check_eq($sformatf("%s_data%0d", tname, i), 128'(rx_dat[i]), 128'(exp_dat[i]));
      check_eq($sformatf("%s_last%0d", tname, i), 128'(rx_last[i]), 128'(i == exp_dat.size() - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    blk_tab[0] = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    blk_tab[1] = {4{32'h11111111}};
    blk_tab[2] = '0;
    blk_tab[3] = '0;

    // Reset state
    @(negedge clk);
    check_eq("rst_ks_next",   128'(ks_next),   128'd0);
    check_eq("rst_in_ready",  128'(in_ready),  128'd0);
    check_eq("rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("rst_out_data",  128'(out_data),  128'd0);
    check_eq("rst_out_last",  128'(out_last),  128'd0);
    check_eq("rst_busy",      128'(busy),      128'd0);
    check_eq("rst_blk_count", 128'(blk_count), 128'd0);

    // Four-word message against a known block
    do_reset();
    do_start();
    check_eq("t1_ks_next_after_start", 128'(ks_next), 128'd1);
    check_eq("t1_busy_after_start",    128'(busy),    128'd1);
    tx_dat = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    exp_dat = '{32'hFFFEFDFC, 32'hFBFAF9F8, 32'hF7F6F5F4, 32'hF3F2F1F0};
    fork
      send_words(4, 1'b1);
      recv_words(4);
    join
    check_rx("t1");
    @(negedge clk);
    check_eq("t1_busy_end",   128'(busy),      128'd0);
    check_eq("t1_blk_count",  128'(blk_count), 128'd1);
    check_eq("t1_ks_pulses",  128'(ks_pulses), 128'd1);

    // Six-word message spanning two blocks
    do_reset();
    do_start();
    tx_dat = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_dat = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 32'h11111111, 32'h11111111};
    fork
      send_words(6, 1'b1);
      recv_words(6);
    join
    check_rx("t2");
    @(negedge clk);
    check_eq("t2_ks_pulses", 128'(ks_pulses), 128'd2);
    check_eq("t2_blk_count", 128'(blk_count), 128'd2);
    check_eq("t2_busy_end",  128'(busy),      128'd0);

    // Output backpressure holds data and blocks input
    do_reset();
    out_ready = 1'b0;
    do_start();
    in_valid = 1'b1; in_data = 32'h0; in_last = 1'b0;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check_eq("t3_in_ready_first", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_data = 32'hFFFF0000; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_eq("t3_hold_valid",    128'(out_valid), 128'd1);
      check_eq("t3_hold_data",     128'(out_data),  128'h00010203);
      check_eq("t3_hold_last",     128'(out_last),  128'd0);
      check_eq("t3_hold_in_ready", 128'(in_ready),  128'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check_eq("t3_second_data",  128'(out_data),  128'hFBFA0607);
    check_eq("t3_second_last",  128'(out_last),  128'd1);
    check_eq("t3_second_valid", 128'(out_valid), 128'd1);
    @(negedge clk);
    check_eq("t3_drained_valid", 128'(out_valid), 128'd0);
    check_eq("t3_busy_end",      128'(busy),      128'd0);
    check_eq("t3_blk_count",     128'(blk_count), 128'd1);

    // Single-word message; start pulses while busy are ignored
    do_reset();
    do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    tx_dat = '{32'h12345678};
    send_words(1, 1'b1);
    check_eq("t4_busy_pending", 128'(busy),     128'd1);
    check_eq("t4_data",         128'(out_data), 128'h1235547B);
    check_eq("t4_last",         128'(out_last), 128'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_busy_after_accept", 128'(busy), 128'd0);
    repeat (20) @(negedge clk);
    check_eq("t4_ks_pulses", 128'(ks_pulses), 128'd1);
    check_eq("t4_busy_idle", 128'(busy),      128'd0);
    check_eq("t4_out_valid", 128'(out_valid), 128'd0);
    check_eq("t4_blk_count", 128'(blk_count), 128'd1);

    // Reset in the middle of a block (idx=2)
    do_reset();
    do_start();
    tx_dat = '{32'hAAAAAAAA, 32'hAAAAAAAA};
    send_words(2, 1'b0);
    check_eq("t5_mid_valid", 128'(out_valid), 128'd1);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_ks_next",   128'(ks_next),   128'd0);
    check_eq("t5_rst_in_ready",  128'(in_ready),  128'd0);
    check_eq("t5_rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("t5_rst_out_data",  128'(out_data),  128'd0);
    check_eq("t5_rst_out_last",  128'(out_last),  128'd0);
    check_eq("t5_rst_busy",      128'(busy),      128'd0);
    check_eq("t5_rst_blk_count", 128'(blk_count), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("t5_no_ks_next", 128'(ks_pulses), 128'd0);
    check_eq("t5_idle_busy",  128'(busy),      128'd0);

`ifdef CTR_KS_PREFETCH_EN
    // Prefetch: second block buffered ahead, no bubble between words 4 and 5
    stub_lat = 12;
    do_reset();
    do_start();
    g = 0;
    while (!(ks_ready && ks_pulses >= 2) && g < 300) begin
      @(negedge clk);
      g++;
    end
    check_eq("pf_second_request", 128'(ks_ready && ks_pulses >= 2), 128'd1);
    tx_dat = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_dat = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};
    fork
      send_words(8, 1'b1);
      recv_words(8);
    join
    check_rx("pf");
    if (rx_cyc.size() == 8) begin
      check_eq("pf_gap_4_5", 128'(rx_cyc[4] - rx_cyc[3]), 128'd1);
    end
    @(negedge clk);
    check_eq("pf_blk_count", 128'(blk_count), 128'd2);
    g = 0;
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq("pf_busy_end", 128'(busy), 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctr_keystream_xor.md
Name: ctr_keystream_xor

Overview:
- Downstream stage of the AES-CTR top.
- Consumes 128-bit keystream blocks from the encryption core (via its next/ready handshake) and XORs them with a streamed plaintext/ciphertext word flow.
- Requests a fresh keystream block each time the current one is used up.
- Outputs the XOR result on a valid/ready stream with last-word marking.

Parameters:
- DATA_W, 32: stream word width; must divide 128 (legal: 8, 16, 32, 64, 128).
- WORDS, 128/DATA_W: derived localparam; words per keystream block.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new message.
- ks_next  out  1  one-cycle pulse to the core: produce next keystream block.
- ks_ready  in  1  core ready level (high idle/done, low while computing).
- ks_block  in  128  core output block, valid while ks_ready=1 after a run.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid&in_ready.
- in_data  in  DATA_W  input word.
- in_last  in  1  marks final word of message.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  in_data XOR keystream word.
- out_last  out  1  copy of in_last for this word.
- busy  out  1  high from start until final word leaves output register.
- blk_count  out  32  keystream blocks consumed since last start; wraps at 2^32.

Behaviour:
- Reset values: ks_next=0, in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, blk_count=0, idx=0, state=IDLE.
- Reset mid-operation aborts everything; no pending ks_next is reissued.
- FSM states:
  - IDLE: on start, go REQ, clear blk_count and idx, set busy.
  - REQ: assert ks_next for exactly this cycle, go DROP.
  - DROP: wait for ks_ready=0, then go WAIT.
  - WAIT: on ks_ready=1, latch ks_block into ks_reg, blk_count+1, go XOR.
  - XOR: stream words; described below.
- start outside IDLE is ignored.
- XOR state:
  - in_ready = (state==XOR) && (!out_valid || out_ready).
  - On input transfer: out_data <= in_data ^ ks_reg[127-idx*DATA_W -: DATA_W] (MSB word first); out_last <= in_last; out_valid <= 1; idx+1.
  - If in_last: go IDLE, idx=0, remaining keystream discarded.
  - Else if idx==WORDS-1: idx=0, go REQ.
- Output register: out_valid clears on out_ready when no new transfer occurs in the same cycle. out_data holds stable while out_valid && !out_ready.
- busy clears the cycle after the out_last word is accepted.
- Minimum latency: start → ks_next 1 cycle; ks_block latch → first out_valid 1 cycle after first input transfer.
- in_last on word 0 of a block is legal: one word out, no further ks_next.
- Same-cycle input transfer and output acceptance: sustains 1 word/clock.

Optional Feature:
- Macro: CTR_KS_PREFETCH_EN.
- With the macro defined:
  - Second 128-bit register ks_nxt plus valid flag.
  - Immediately after latching a block into ks_reg, issue ks_next (REQ/DROP/WAIT run concurrently with XOR) and fill ks_nxt.
  - At block end, if ks_nxt valid: swap into ks_reg with no bubble and blk_count+1; else wait in WAIT.
  - On in_last, discard ks_nxt (not counted), but still wait for any outstanding core run to finish (ks_ready=1) before IDLE accepts start.
- Without the macro: single buffer; bubble of ≥ core latency + 3 cycles between blocks.

Test Plan:
- Reset asserted mid-XOR (idx=2) → all outputs 0 same cycle; after release, no ks_next until start.
- Core stub returns ks_block=128'h00010203_04050607_08090A0B_0C0D0E0F; start, input words 32'hFFFFFFFF ×4 with last on 4th → out_data FFFEFDFC, FBFAF9F8, F7F6F5F4, F3F2F1F0; out_last only on 4th; blk_count=1; exactly one ks_next pulse.
- 6-word message, second stub block 128'h1111…11, inputs 0 → words 5-6 = 32'h11111111; two ks_next pulses; blk_count=2.
- out_ready held low 5 cycles with out_valid=1 → out_data stable; in_ready=0; no input consumed.
- Single-word message (in_last on word 0) → one output, busy drops after accept, only one ks_next; start while busy ignored.
- CTR_KS_PREFETCH_EN, 8-word message, stub latency 12 cycles, continuous in_valid/out_ready → no gap in out_valid between word 4 and word 5; blk_count=2.
